// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Purpose : shared ALU opcode encodings and arbiter state encoding used by the
//           ALU arbiter and its round-robin picker.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [1:0] ALU_ILL = 2'b00;
   localparam logic [1:0] ALU_OR  = 2'b01;
   localparam logic [1:0] ALU_ADD = 2'b10;
   localparam logic [1:0] ALU_SUB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_grant2.sv
// ---------------------------------------------------------------------------
// rr_grant2
// Purpose : combinational two-way round-robin picker. A lone valid requester
//           wins; on a tie the requester that was not granted last wins.
// Ports   : valid_i[1:0]  request valids (bit n = requester n)
//           rr_last_i     id of the most recently accepted requester
//           gnt_o[1:0]    one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_grant2 (
   input  logic [1:0] valid_i,
   input  logic       rr_last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (valid_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = rr_last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Purpose : shares one external combinational ALU between two requesters with
//           round-robin grant, optional bounded lock, and a registered
//           one-cycle response per accepted op.
// Ports   : clk, reset (async, active-high)
//           rN_valid/rN_ready/rN_lock/rN_a/rN_b/rN_op   request side (N=0,1)
//           rN_rsp_valid/rN_rsp_s/rN_rsp_zero/rN_rsp_err response side
//           alu_a/alu_b/alu_op -> ALU, alu_s/alu_zero <- ALU
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic             r0_lock,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic [1:0]       r0_op,
   output logic             r0_rsp_valid,
   output logic [WIDTH-1:0] r0_rsp_s,
   output logic             r0_rsp_zero,
   output logic             r0_rsp_err,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic             r1_lock,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   input  logic [1:0]       r1_op,
   output logic             r1_rsp_valid,
   output logic [WIDTH-1:0] r1_rsp_s,
   output logic             r1_rsp_zero,
   output logic             r1_rsp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_s,
   input  logic             alu_zero
);

   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   arb_state_e       state_q, state_d;
   logic             rr_last_q, rr_last_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

   logic [1:0] gnt;
   logic       acc0, acc1;
   logic       acc_lock, own_lock;

   logic             r0_rsp_valid_q, r1_rsp_valid_q;
   logic [WIDTH-1:0] r0_rsp_s_q, r0_rsp_s_d, r1_rsp_s_q, r1_rsp_s_d;
   logic             r0_rsp_zero_q, r0_rsp_zero_d, r1_rsp_zero_q, r1_rsp_zero_d;
   logic             r0_rsp_err_q, r0_rsp_err_d, r1_rsp_err_q, r1_rsp_err_d;

   rr_grant2 u_rr_grant2 (
      .valid_i   ({r1_valid, r0_valid}),
      .rr_last_i (rr_last_q),
      .gnt_o     (gnt)
   );

   // State, round-robin pointer and lock counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rr_last_q  <= 1'b1;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Next-state: ownership entry, lock counting and forced release
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      lock_cnt_d = lock_cnt_q;
      acc_lock   = acc1 ? r1_lock : r0_lock;
      own_lock   = (state_q == ST_OWN1) ? r1_lock : r0_lock;

      if (acc0)      rr_last_d = 1'b0;
      else if (acc1) rr_last_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            // LOCK_MAX==1 means a locked accept already exhausts the budget
            if ((acc0 || acc1) && acc_lock && (CNT_ONE != CNT_MAX)) begin
               state_d    = acc1 ? ST_OWN1 : ST_OWN0;
               lock_cnt_d = CNT_ONE;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (acc0 || acc1) begin
               if (acc_lock && (lock_cnt_q + CNT_ONE != CNT_MAX)) begin
                  lock_cnt_d = lock_cnt_q + CNT_ONE;
               end else begin
                  state_d    = ST_IDLE;
                  lock_cnt_d = '0;
               end
            end else if (!own_lock) begin
               state_d    = ST_IDLE;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   // Outputs: grant, accept and ALU drive (idle/illegal cycles send a safe OR 0,0)
   always_comb begin
      r0_ready = 1'b0;
      r1_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            r0_ready = gnt[0];
            r1_ready = gnt[1];
         end
         ST_OWN0: r0_ready = 1'b1;
         ST_OWN1: r1_ready = 1'b1;
         default: ;
      endcase
      acc0 = r0_valid & r0_ready;
      acc1 = r1_valid & r1_ready;

      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_OR;
      if (acc0 && (r0_op != ALU_ILL)) begin
         alu_a  = r0_a;
         alu_b  = r0_b;
         alu_op = r0_op;
      end else if (acc1 && (r1_op != ALU_ILL)) begin
         alu_a  = r1_a;
         alu_b  = r1_b;
         alu_op = r1_op;
      end
   end

   // Response payload capture; payload holds when nothing is accepted
   always_comb begin
      r0_rsp_s_d    = r0_rsp_s_q;
      r0_rsp_zero_d = r0_rsp_zero_q;
      r0_rsp_err_d  = r0_rsp_err_q;
      r1_rsp_s_d    = r1_rsp_s_q;
      r1_rsp_zero_d = r1_rsp_zero_q;
      r1_rsp_err_d  = r1_rsp_err_q;
      if (acc0) begin
         r0_rsp_err_d  = (r0_op == ALU_ILL);
         r0_rsp_s_d    = (r0_op == ALU_ILL) ? '0 : alu_s;
         r0_rsp_zero_d = (r0_op == ALU_ILL) ? 1'b0 : alu_zero;
      end
      if (acc1) begin
         r1_rsp_err_d  = (r1_op == ALU_ILL);
         r1_rsp_s_d    = (r1_op == ALU_ILL) ? '0 : alu_s;
         r1_rsp_zero_d = (r1_op == ALU_ILL) ? 1'b0 : alu_zero;
      end
   end

   // Response registers; reset drops any pending response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r0_rsp_valid_q <= 1'b0;
         r0_rsp_s_q     <= '0;
         r0_rsp_zero_q  <= 1'b0;
         r0_rsp_err_q   <= 1'b0;
         r1_rsp_valid_q <= 1'b0;
         r1_rsp_s_q     <= '0;
         r1_rsp_zero_q  <= 1'b0;
         r1_rsp_err_q   <= 1'b0;
      end else begin
         r0_rsp_valid_q <= acc0;
         r0_rsp_s_q     <= r0_rsp_s_d;
         r0_rsp_zero_q  <= r0_rsp_zero_d;
         r0_rsp_err_q   <= r0_rsp_err_d;
         r1_rsp_valid_q <= acc1;
         r1_rsp_s_q     <= r1_rsp_s_d;
         r1_rsp_zero_q  <= r1_rsp_zero_d;
         r1_rsp_err_q   <= r1_rsp_err_d;
      end
   end

   assign r0_rsp_valid = r0_rsp_valid_q;
   assign r0_rsp_s     = r0_rsp_s_q;
   assign r0_rsp_zero  = r0_rsp_zero_q;
   assign r0_rsp_err   = r0_rsp_err_q;
   assign r1_rsp_valid = r1_rsp_valid_q;
   assign r1_rsp_s     = r1_rsp_s_q;
   assign r1_rsp_zero  = r1_rsp_zero_q;
   assign r1_rsp_err   = r1_rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Purpose : directed bench for alu_arbiter with a behavioural ALU attached.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             reset;
   logic             r0_valid, r0_ready, r0_lock;
   logic [WIDTH-1:0] r0_a, r0_b;
   logic [1:0]       r0_op;
   logic             r0_rsp_valid, r0_rsp_zero, r0_rsp_err;
   logic [WIDTH-1:0] r0_rsp_s;
   logic             r1_valid, r1_ready, r1_lock;
   logic [WIDTH-1:0] r1_a, r1_b;
   logic [1:0]       r1_op;
   logic             r1_rsp_valid, r1_rsp_zero, r1_rsp_err;
   logic [WIDTH-1:0] r1_rsp_s;
   logic [WIDTH-1:0] alu_a, alu_b, alu_s;
   logic [1:0]       alu_op;
   logic             alu_zero;

   int checks   = 0;
   int failures = 0;

   alu_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .r0_valid     (r0_valid),
      .r0_ready     (r0_ready),
      .r0_lock      (r0_lock),
      .r0_a         (r0_a),
      .r0_b         (r0_b),
      .r0_op        (r0_op),
      .r0_rsp_valid (r0_rsp_valid),
      .r0_rsp_s     (r0_rsp_s),
      .r0_rsp_zero  (r0_rsp_zero),
      .r0_rsp_err   (r0_rsp_err),
      .r1_valid     (r1_valid),
      .r1_ready     (r1_ready),
      .r1_lock      (r1_lock),
      .r1_a         (r1_a),
      .r1_b         (r1_b),
      .r1_op        (r1_op),
      .r1_rsp_valid (r1_rsp_valid),
      .r1_rsp_s     (r1_rsp_s),
      .r1_rsp_zero  (r1_rsp_zero),
      .r1_rsp_err   (r1_rsp_err),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_s        (alu_s),
      .alu_zero     (alu_zero)
   );

   // Behavioural stand-in for the external ALU
   always_comb begin
      case (alu_op)
         2'b01:   alu_s = alu_a | alu_b;
         2'b10:   alu_s = alu_a + alu_b;
         2'b11:   alu_s = alu_a - alu_b;
         default: alu_s = 32'hDEAD_BEEF;
      endcase
      alu_zero = (alu_s == 32'd0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req0(input logic v, input logic l, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
      r0_valid = v; r0_lock = l; r0_op = op; r0_a = a; r0_b = b;
   endtask

   task automatic req1(input logic v, input logic l, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
      r1_valid = v; r1_lock = l; r1_op = op; r1_a = a; r1_b = b;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req0(1'b0, 1'b0, 2'b01, 32'd0, 32'd0);
      req1(1'b0, 1'b0, 2'b01, 32'd0, 32'd0);
      step();
      step();
      chk("rst_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
      chk("rst_r0_rsp_s",     r0_rsp_s,          32'd0);
      chk("rst_r1_rsp_err",   32'(r1_rsp_err),   32'd0);
      chk("rst_alu_op_idle",  32'(alu_op),       32'd1);
      reset = 1'b0;

      // 1: single requester ADD, then wrap-around to zero
      req0(1'b1, 1'b0, 2'b10, 32'd5, 32'd7);
      #1;
      chk("t1_r0_ready",  32'(r0_ready), 32'd1);
      chk("t1_r1_ready",  32'(r1_ready), 32'd0);
      chk("t1_alu_op",    32'(alu_op),   32'd2);
      chk("t1_alu_a",     alu_a,         32'd5);
      step();
      chk("t1_rsp_valid", 32'(r0_rsp_valid), 32'd1);
      chk("t1_rsp_s",     r0_rsp_s,          32'd12);
      chk("t1_rsp_zero",  32'(r0_rsp_zero),  32'd0);
      req0(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'd1);
      step();
      chk("t1_wrap_valid", 32'(r0_rsp_valid), 32'd1);
      chk("t1_wrap_s",     r0_rsp_s,          32'd0);
      chk("t1_wrap_zero",  32'(r0_rsp_zero),  32'd1);
      req0(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
      step();
      chk("t1_strobe_drop", 32'(r0_rsp_valid), 32'd0);
      chk("t1_hold_zero",   32'(r0_rsp_zero),  32'd1);

      // 2: tie after reset goes to r0, then r1 served
      reset_pulse();
      req0(1'b1, 1'b0, 2'b11, 32'd3, 32'd3);
      req1(1'b1, 1'b0, 2'b01, 32'h0000_00F0, 32'h0000_000F);
      #1;
      chk("t2_tie_r0_ready", 32'(r0_ready), 32'd1);
      chk("t2_tie_r1_ready", 32'(r1_ready), 32'd0);
      step();
      chk("t2_sub_valid", 32'(r0_rsp_valid), 32'd1);
      chk("t2_sub_s",     r0_rsp_s,          32'd0);
      chk("t2_sub_zero",  32'(r0_rsp_zero),  32'd1);
      req0(1'b0, 1'b0, 2'b11, 32'd0, 32'd0);
      #1;
      chk("t2_r1_ready", 32'(r1_ready), 32'd1);
      step();
      chk("t2_or_valid",    32'(r1_rsp_valid), 32'd1);
      chk("t2_or_s",        r1_rsp_s,          32'h0000_00FF);
      chk("t2_r0_no_rsp",   32'(r0_rsp_valid), 32'd0);

      // 3: r1 locks for 3 accepts, unlocked 4th; r0 waits then wins
      req1(1'b0, 1'b0, 2'b01, 32'd0, 32'd0);
      req0(1'b1, 1'b0, 2'b10, 32'd1, 32'd1);
      step();
      req0(1'b1, 1'b0, 2'b10, 32'd2, 32'd2);
      for (int i = 0; i < 4; i++) begin
         req1(1'b1, (i < 3), 2'b10, 32'd10, 32'(i));
         #1;
         chk($sformatf("t3_r0_blocked_%0d", i), 32'(r0_ready), 32'd0);
         chk($sformatf("t3_r1_granted_%0d", i), 32'(r1_ready), 32'd1);
         step();
         chk($sformatf("t3_r1_rsp_s_%0d", i), r1_rsp_s, 32'(10 + i));
      end
      req1(1'b1, 1'b0, 2'b10, 32'd10, 32'd9);
      #1;
      chk("t3_r0_ready_c5", 32'(r0_ready), 32'd1);
      chk("t3_r1_ready_c5", 32'(r1_ready), 32'd0);
      step();
      chk("t3_r0_rsp_valid", 32'(r0_rsp_valid), 32'd1);
      chk("t3_r0_rsp_s",     r0_rsp_s,          32'd4);
      chk("t3_r1_no_rsp",    32'(r1_rsp_valid), 32'd0);

      // 4: r0 held lock is forcibly released after 8 accepts
      req0(1'b1, 1'b1, 2'b10, 32'd1, 32'd1);
      req1(1'b1, 1'b0, 2'b01, 32'd1, 32'd2);
      reset_pulse();
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("t4_r0_ready_%0d", i), 32'(r0_ready), 32'd1);
         chk($sformatf("t4_r1_wait_%0d", i),  32'(r1_ready), 32'd0);
         step();
      end
      chk("t4_r0_ready_c9", 32'(r0_ready), 32'd0);
      chk("t4_r1_ready_c9", 32'(r1_ready), 32'd1);
      req0(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
      step();
      chk("t4_r1_rsp_valid", 32'(r1_rsp_valid), 32'd1);
      chk("t4_r1_rsp_s",     r1_rsp_s,          32'd3);

      // 5: illegal op never reaches the ALU and reports err
      req1(1'b1, 1'b0, 2'b00, 32'd5, 32'd9);
      #1;
      chk("t5_r1_ready", 32'(r1_ready), 32'd1);
      chk("t5_alu_op",   32'(alu_op),   32'd1);
      chk("t5_alu_a",    alu_a,         32'd0);
      chk("t5_alu_b",    alu_b,         32'd0);
      step();
      chk("t5_rsp_valid", 32'(r1_rsp_valid), 32'd1);
      chk("t5_rsp_err",   32'(r1_rsp_err),   32'd1);
      chk("t5_rsp_s",     r1_rsp_s,          32'd0);
      chk("t5_rsp_zero",  32'(r1_rsp_zero),  32'd0);
      req1(1'b1, 1'b0, 2'b01, 32'd4, 32'd8);
      step();
      chk("t5_err_clear", 32'(r1_rsp_err), 32'd0);
      chk("t5_next_s",    r1_rsp_s,        32'd12);

      // 6: reset while in OWN0 with response pending
      req1(1'b0, 1'b0, 2'b01, 32'd0, 32'd0);
      req0(1'b1, 1'b1, 2'b10, 32'd2, 32'd3);
      step();
      chk("t6_pending_valid", 32'(r0_rsp_valid), 32'd1);
      req0(1'b0, 1'b1, 2'b10, 32'd2, 32'd3);
      req1(1'b1, 1'b0, 2'b01, 32'd1, 32'd0);
      reset = 1'b1;
      #1;
      chk("t6_rst_rsp_valid", 32'(r0_rsp_valid), 32'd0);
      chk("t6_rst_rsp_s",     r0_rsp_s,          32'd0);
      chk("t6_rst_idle_r1",   32'(r1_ready),     32'd1);
      reset = 1'b0;
      req0(1'b1, 1'b0, 2'b10, 32'd6, 32'd1);
      #1;
      chk("t6_tie_r0_ready", 32'(r0_ready), 32'd1);
      chk("t6_tie_r1_ready", 32'(r1_ready), 32'd0);
      step();
      chk("t6_r0_rsp_s", r0_rsp_s, 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
